// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage feeding the control/decode unit. Owns the program
// counter, drives a combinational byte-addressed big-endian instruction
// memory, and registers each fetched word with its PC into the IF/ID holding
// register. Handles stalls, branch/jump redirects (including a redirect that
// arrives while stalled), bubble injection via flush, and sticky fetch faults.
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-high reset
//   stall           in   hold PC and IF/ID this cycle
//   flush           in   load a bubble into IF/ID at the next edge
//   redirect_valid  in   next PC is redirect_target
//   redirect_target in   redirect destination byte address [31:0]
//   imem_addr       out  current PC to instruction memory [31:0]
//   imem_rdata      in   instruction word at imem_addr (combinational) [31:0]
//   if_id_instr     out  registered instruction to decode [31:0]
//   if_id_pc        out  PC of if_id_instr [31:0]
//   if_id_pc_plus4  out  if_id_pc + 4 [31:0]
//   if_id_valid     out  if_id_instr is a real instruction, not a bubble
//   fault           out  sticky fetch-fault flag
//   fault_pc        out  PC that caused the fault [31:0]
//   fetch_count     out  instructions accepted into IF/ID [31:0]
//   dbg_state       out  FSM state (0=RUN, 1=HOLD, 2=FAULT) [1:0]
//
// Handshake: there is no valid/ready pair here. Decode consumes IF/ID every
// cycle it is valid; back-pressure is expressed by stall, which freezes both
// the PC and IF/ID. flush overrides stall for IF/ID contents only.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  state_t      r_state,   w_state;
  logic [31:0] r_pc,      w_pc;
  logic [31:0] r_instr,   w_instr;
  logic [31:0] r_ifpc,    w_ifpc;
  logic [31:0] r_ifpc4,   w_ifpc4;
  logic        r_valid,   w_valid;
  logic        r_fault,   w_fault;
  logic [31:0] r_fpc,     w_fpc;
  logic [31:0] r_count,   w_count;
  logic [31:0] r_pending, w_pending;

  logic        w_fetch_bad;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_fetch_bad = (r_pc[1:0] != 2'b00) || (r_pc > LAST_PC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_ifpc    <= 32'd0;
      r_ifpc4   <= 32'd0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
      r_fpc     <= 32'd0;
      r_count   <= 32'd0;
      r_pending <= 32'd0;
    end else begin
      r_state   <= w_state;
      r_pc      <= w_pc;
      r_instr   <= w_instr;
      r_ifpc    <= w_ifpc;
      r_ifpc4   <= w_ifpc4;
      r_valid   <= w_valid;
      r_fault   <= w_fault;
      r_fpc     <= w_fpc;
      r_count   <= w_count;
      r_pending <= w_pending;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_pc      = r_pc;
    w_instr   = r_instr;
    w_ifpc    = r_ifpc;
    w_ifpc4   = r_ifpc4;
    w_valid   = r_valid;
    w_fault   = r_fault;
    w_fpc     = r_fpc;
    w_count   = r_count;
    w_pending = r_pending;

    if (r_state != ST_FAULT) begin
      if (!stall && w_fetch_bad) begin
        // Bad fetch address: freeze with a bubble in IF/ID until reset.
        w_fault = 1'b1;
        w_fpc   = r_pc;
        w_instr = 32'd0;
        w_ifpc  = 32'd0;
        w_ifpc4 = 32'd0;
        w_valid = 1'b0;
        w_state = ST_FAULT;
      end else begin
        if (stall) begin
          // Remember the latest redirect seen while stalled; the word at the
          // current PC (delay slot) still has to be fetched first.
          if (redirect_valid) begin
            w_pending = redirect_target;
            w_state   = ST_HOLD;
          end
        end else begin
          w_instr = imem_rdata;
          w_ifpc  = r_pc;
          w_ifpc4 = w_pc_plus4;
          w_valid = 1'b1;
          if (!flush) begin
            w_count = r_count + 32'd1;
          end
          // A same-cycle redirect beats one captured during the stall.
          if (redirect_valid) begin
            w_pc = redirect_target;
          end else if (r_state == ST_HOLD) begin
            w_pc = r_pending;
          end else begin
            w_pc = w_pc_plus4;
          end
          w_state = ST_RUN;
        end
        // flush wins over both stall and a normal fetch for IF/ID contents.
        if (flush) begin
          w_instr = 32'd0;
          w_ifpc  = 32'd0;
          w_ifpc4 = 32'd0;
          w_valid = 1'b0;
        end
      end
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc       = r_ifpc;
  assign if_id_pc_plus4 = r_ifpc4;
  assign if_id_valid    = r_valid;
  assign fault          = r_fault;
  assign fault_pc       = r_fpc;
  assign fetch_count    = r_count;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] ST_RUN   = 32'd0;
  localparam logic [31:0] ST_HOLD  = 32'd1;
  localparam logic [31:0] ST_FAULT = 32'd2;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:127];
  logic [31:0] exp_q [$];

  int tests_run;
  int tests_failed;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(512)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count),
    .dbg_state      (dbg_state)
  );

  // Big-endian word memory, one word per aligned address.
  assign imem_rdata = mem[imem_addr[8:2]];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic s, input logic f, input logic rv,
                        input logic [31:0] rt);
    stall           = s;
    flush           = f;
    redirect_valid  = rv;
    redirect_target = rt;
  endtask

  // Advance one clock edge; outputs are sampled 1ns afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_w;
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 128; i++) mem[i] = {16'hC0DE, 16'(i * 4)};
    mem[0] = 32'h2401_002C;
    mem[1] = 32'h9022_0000;
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    #12;
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_state", {30'd0, dbg_state}, ST_RUN);

    // Sequential fetch of the first two words
    step();
    check("f0_instr", if_id_instr, 32'h2401_002C);
    check("f0_pc",    if_id_pc, 32'h0);
    check("f0_valid", {31'd0, if_id_valid}, 32'd1);
    step();
    check("f1_instr", if_id_instr, 32'h9022_0000);
    check("f1_pc",    if_id_pc, 32'h4);
    check("f1_pc4",   if_id_pc_plus4, 32'h8);
    check("f1_count", fetch_count, 32'd2);

    // Redirect at pc=0x18 back to 0x14
    repeat (4) step();
    check("br_at", imem_addr, 32'h18);
    set_in(1'b0, 1'b0, 1'b1, 32'h14);
    step();
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    check("br_addr",  imem_addr, 32'h14);
    check("br_ifpc0", if_id_pc, 32'h18);
    check("br_inst0", if_id_instr, 32'hC0DE_0018);
    step();
    check("br_ifpc1", if_id_pc, 32'h14);
    check("br_count", fetch_count, 32'd8);

    // Stall with two redirects; last one wins, delay slot fetched first
    repeat (3) step();
    check("st_at", imem_addr, 32'h24);
    set_in(1'b1, 1'b0, 1'b1, 32'h30);
    step();
    check("st_state", {30'd0, dbg_state}, ST_HOLD);
    check("st_hold_ifpc", if_id_pc, 32'h20);
    set_in(1'b1, 1'b0, 1'b1, 32'h2C);
    step();
    set_in(1'b1, 1'b0, 1'b0, 32'd0);
    step();
    check("st_hold_addr",  imem_addr, 32'h24);
    check("st_hold_count", fetch_count, 32'd11);
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check("st_slot_instr", if_id_instr, 32'hC0DE_0024);
    check("st_slot_pc",    if_id_pc, 32'h24);
    check("st_new_addr",   imem_addr, 32'h2C);
    check("st_count",      fetch_count, 32'd12);
    check("st_run",        {30'd0, dbg_state}, ST_RUN);
    step();
    check("st_tgt_pc", if_id_pc, 32'h2C);

    // Stall + flush at pc=0x10
    set_in(1'b0, 1'b0, 1'b1, 32'h10);
    step();
    check("fl_count0", fetch_count, 32'd14);
    set_in(1'b1, 1'b1, 1'b0, 32'd0);
    step();
    check("fl_valid", {31'd0, if_id_valid}, 32'd0);
    check("fl_instr", if_id_instr, 32'h0);
    check("fl_ifpc",  if_id_pc, 32'h0);
    check("fl_addr",  imem_addr, 32'h10);
    check("fl_count", fetch_count, 32'd14);
    // flush alone: PC advances, no count
    set_in(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    check("fl2_valid", {31'd0, if_id_valid}, 32'd0);
    check("fl2_addr",  imem_addr, 32'h14);
    check("fl2_count", fetch_count, 32'd14);

    // Misaligned redirect faults and freezes
    set_in(1'b0, 1'b0, 1'b1, 32'h22);
    step();
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    check("mis_addr", imem_addr, 32'h22);
    step();
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_fpc",   fault_pc, 32'h22);
    check("mis_valid", {31'd0, if_id_valid}, 32'd0);
    check("mis_state", {30'd0, dbg_state}, ST_FAULT);
    for (int i = 0; i < 5; i++) begin
      set_in(i[0], 1'b0, 1'b1, 32'h40);
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    check("frz_addr",  imem_addr, 32'h22);
    check("frz_fault", {31'd0, fault}, 32'd1);
    check("frz_fpc",   fault_pc, 32'h22);
    check("frz_count", fetch_count, 32'd15);
    pulse_reset();
    check("clr_fault", {31'd0, fault}, 32'd0);
    check("clr_addr",  imem_addr, 32'h0);
    check("clr_count", fetch_count, 32'd0);

    // Run the whole legal range, then fault past the end
    for (int a = 0; a < 32'h1FC; a += 4) begin
      exp_q.push_back(mem[a[8:2]]);
      step();
      exp_w = exp_q.pop_front();
      check("seq_instr", if_id_instr, exp_w);
    end
    check("end_addr", imem_addr, 32'h1FC);
    step();
    check("end_instr", if_id_instr, 32'hC0DE_01FC);
    check("end_ifpc",  if_id_pc, 32'h1FC);
    check("end_pc4",   if_id_pc_plus4, 32'h200);
    check("end_fault", {31'd0, fault}, 32'd0);
    check("end_count", fetch_count, 32'd128);
    step();
    check("oob_fault", {31'd0, fault}, 32'd1);
    check("oob_fpc",   fault_pc, 32'h200);
    check("oob_valid", {31'd0, if_id_valid}, 32'd0);
    check("oob_count", fetch_count, 32'd128);

    // Async reset in HOLD between edges discards the pending target
    pulse_reset();
    step();
    step();
    set_in(1'b1, 1'b0, 1'b1, 32'h40);
    step();
    check("ar_hold", {30'd0, dbg_state}, ST_HOLD);
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    #1;
    check("ar_state", {30'd0, dbg_state}, ST_RUN);
    check("ar_addr",  imem_addr, 32'h0);
    check("ar_valid", {31'd0, if_id_valid}, 32'd0);
    check("ar_ifpc",  if_id_pc, 32'h0);
    check("ar_count", fetch_count, 32'd0);
    reset = 1'b0;
    step();
    check("ar_next_addr", imem_addr, 32'h4);
    check("ar_next_pc",   if_id_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=%08h exp=%08h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the control/decode unit.
- Owns the program counter and drives the byte-addressed, big-endian, combinational instruction memory.
- Registers each fetched word and its PC into an IF/ID holding register that feeds decode.
- Handles stalls, branch/jump redirects (including a redirect that arrives during a stall), bubble injection, and fetch faults.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_BYTES, 512, instruction memory size in bytes; the legal fetch range is 0 to IMEM_BYTES-4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold the PC and IF/ID contents this cycle
- flush  input  1  load a bubble into IF/ID at the next edge
- redirect_valid  input  1  the next PC is redirect_target (branch taken / jump)
- redirect_target  input  32  redirect destination byte address
- imem_addr  output  32  current PC, driven to instruction memory
- imem_rdata  input  32  instruction word at imem_addr, combinational
- if_id_instr  output  32  registered instruction to decode
- if_id_pc  output  32  PC of if_id_instr
- if_id_pc_plus4  output  32  if_id_pc + 4
- if_id_valid  output  1  if_id_instr is a real instruction, not a bubble
- fault  output  1  sticky fetch-fault flag
- fault_pc  output  32  PC that caused the fault
- fetch_count  output  32  count of instructions accepted into IF/ID

Behaviour:
- Reset (async, any time, including mid-stall or in HOLD):
  - pc=RESET_PC; if_id_instr=0 (SLL r0 NOP); if_id_pc=0; if_id_pc_plus4=0; if_id_valid=0.
  - fault=0; fault_pc=0; fetch_count=0; pending_target=0; state=RUN.
- imem_addr = pc, combinationally, in all states.
- Fetch latency: a word presented on imem_rdata in cycle N appears on if_id_instr after edge N. Decode sees it in cycle N+1.
- FSM states: RUN, HOLD (redirect captured while stalled), FAULT.
- Fault check, done every non-FAULT edge before any update:
  - fetch_bad = pc[1:0]!=0 OR pc > IMEM_BYTES-4, computed on the current pc.
  - If fetch_bad and stall=0: fault<=1, fault_pc<=pc, IF/ID<=bubble, state<=FAULT.
  - While stall=1 the fault check is deferred.
- RUN, stall=0, no fault:
  - IF/ID <= {imem_rdata, pc, pc+4}; if_id_valid<=1; fetch_count<=fetch_count+1.
  - pc <= redirect_valid ? redirect_target : pc+4.
- RUN, stall=1:
  - pc and IF/ID hold; fetch_count holds.
  - If redirect_valid: pending_target<=redirect_target, state<=HOLD.
- HOLD, stall=1: hold everything. A new redirect_valid overwrites pending_target (last one wins).
- HOLD, stall=0:
  - The instruction at the current pc is fetched normally, so the delay slot is preserved.
  - pc <= redirect_valid ? redirect_target : pending_target, i.e. a same-cycle redirect beats the pending one.
  - state<=RUN.
- flush=1 (RUN/HOLD):
  - At the edge, IF/ID<=bubble (instr=0, valid=0, pc fields=0), regardless of stall.
  - fetch_count does not increment.
  - PC update follows the stall/redirect rules above unchanged.
  - flush beats stall for IF/ID only.
- FAULT:
  - pc, IF/ID bubble, fault and fault_pc frozen; all inputs ignored.
  - Exit is by reset only.
- Arithmetic:
  - pc+4 and if_id_pc_plus4 are 32-bit modulo 2^32, no carry out.
  - fetch_count wraps from 2^32-1 to 0.
- A misaligned redirect_target is accepted into pc without check; it faults at the next non-stalled edge.
- There is no internal write path to instruction memory.

Test Plan:
- Reset, then load imem with 0x2401002C at 0 and 0x90220000 at 4; run 2 edges -> if_id_instr=0x2401002C, if_id_pc=0, if_id_valid=1, then 0x90220000, if_id_pc=4, pc_plus4=8; fetch_count=2.
- At pc=0x18 assert redirect_valid with target 0x14 for one edge -> next imem_addr=0x14; an IF/ID holding pc=0x18 is followed by pc=0x14.
- At pc=0x24 assert stall for 3 cycles with redirect target 0x30 in cycle 1 and 0x2C in cycle 2; release -> IF/ID gets the word at 0x24, then pc=0x2C; fetch_count advances by exactly 1 across the stall.
- Assert stall and flush together at pc=0x10 -> if_id_valid=0, if_id_instr=0, pc stays 0x10, fetch_count unchanged.
- Redirect to 0x22 -> next edge fault=1, fault_pc=0x22, if_id_valid=0; 5 more edges with redirects change nothing; reset clears fault and pc=0.
- Run to pc=0x1FC, then one edge -> fetch at 0x1FC succeeds; the following edge at 0x200 faults with fault_pc=0x200.
- Assert reset asynchronously in HOLD between clock edges -> outputs reach their reset values immediately, without waiting for an edge; the pending target is discarded.
